// File: rtl/switch_debouncer_pkg.sv
// Shared constants for the switch debouncer: board clock, channel count,
// debounce window and counter width defaults, plus the counter-width check
// used when the block is elaborated.
// Optional feature macro: SWITCH_DEBOUNCER_EDGE_EN (registered rise/fall pulses).
package switch_debouncer_pkg;

  // Board clock for the logic-gate lab boards.
  localparam int BOARD_CLK_HZ = 50_000_000;

  // Two inputs feed the a/b pins of a 2-input gate.
  localparam int DEF_N_CH = 2;

  // 10 ms of stable level at the board clock.
  localparam int DEF_DEBOUNCE_CYC = BOARD_CLK_HZ / 100;

  // Wide enough to hold DEF_DEBOUNCE_CYC-1.
  localparam int DEF_CNT_W = 20;

  // True when a CNT_W-bit counter can reach cyc-1 without wrapping.
  function automatic bit cnt_w_ok(input int cyc, input int w);
    longint lim;
    if (w < 1) return 1'b0;
    if (w >= 62) return 1'b1;
    lim = longint'(1) << w;
    return lim > longint'(cyc - 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: 2-flop synchroniser, stability counter and output
// register. With SWITCH_DEBOUNCER_EDGE_EN defined it also registers one-cycle
// rise/fall pulses aligned with the output change; otherwise those outputs
// are tied low and no edge flops exist.
//
// Qualification: the counter only runs while the synchronised level differs
// from the accepted output. Any cycle where they agree (a glitch ending)
// clears it, so only an unbroken run of DEBOUNCE_CYC differing samples is
// accepted. The counter stops at DEBOUNCE_CYC-1 and never wraps.
module debounce_channel
  import switch_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_i,
  output logic sw_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic             s1_q;
  logic             s2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             out_q;
  logic             out_d;
  logic             accept;

  // A new level is accepted on the edge where the counter sits at its
  // maximum and the synchronised input still disagrees with the output.
  assign accept = (s2_q != out_q) && (cnt_q == CNT_MAX);

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= sw_i;
      s2_q <= s1_q;
    end
  end

  // Next counter / output values from the current qualification state.
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (s2_q == out_q) begin
      cnt_d = '0;
    end else if (accept) begin
      out_d = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Stability counter and accepted-level register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign sw_o = out_q;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
  logic rise_q;
  logic fall_q;

  // Edge pulses load on the same edge as the output change, so they are
  // high for exactly the first cycle of the new level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= accept & s2_q;
      fall_q <= accept & ~s2_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// Input-conditioning stage for the logic-gate labs: N_CH independent
// synchronise-and-debounce channels. Raw pins pass through here before any
// gate logic sees them.
// Optional feature macro: SWITCH_DEBOUNCER_EDGE_EN enables registered
// sw_rise/sw_fall pulses; without it both are constant 0.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int N_CH         = DEF_N_CH,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sw_in,
  output logic [N_CH-1:0] sw_out,
  output logic [N_CH-1:0] sw_rise,
  output logic [N_CH-1:0] sw_fall
);

  // Reject configurations that would need a zero-length window or a
  // counter that wraps before reaching DEBOUNCE_CYC-1.
  if (DEBOUNCE_CYC < 1) begin : g_bad_cyc
    $error("switch_debouncer: DEBOUNCE_CYC must be >= 1");
  end
  if (!cnt_w_ok(DEBOUNCE_CYC, CNT_W)) begin : g_bad_cnt_w
    $error("switch_debouncer: CNT_W too narrow for DEBOUNCE_CYC");
  end

  // One fully independent debouncer per channel.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .sw_i  (sw_in[i]),
      .sw_o  (sw_out[i]),
      .rise_o(sw_rise[i]),
      .fall_o(sw_fall[i])
    );
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer (N_CH=2, DEBOUNCE_CYC=4, CNT_W=3).
// Each cycle the driver pushes the expected {sw_fall, sw_rise, sw_out} from a
// small behavioural model onto exp_q; each scenario pops and compares after
// the edge, and adds its own timing checks with hand-derived edge numbers.
module tb_switch_debouncer;

  localparam int NCH  = 2;
  localparam int DCYC = 4;
  localparam int CW   = 3;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
  localparam logic EDGE_EXP = 1'b1;
`else
  localparam logic EDGE_EXP = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic [NCH-1:0] sw_in;
  logic [NCH-1:0] sw_out;
  logic [NCH-1:0] sw_rise;
  logic [NCH-1:0] sw_fall;

  int n_total = 0;
  int n_pass  = 0;

  logic [3*NCH-1:0] exp_q[$];

  // Reference model state.
  logic [NCH-1:0] m_s1, m_s2, m_out, m_rise, m_fall;
  int             m_cnt[NCH];

  switch_debouncer #(
    .N_CH        (NCH),
    .DEBOUNCE_CYC(DCYC),
    .CNT_W       (CW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_in  (sw_in),
    .sw_out (sw_out),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall)
  );

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of one rising edge.
  task automatic model_step(input logic [NCH-1:0] in, input logic r);
    for (int ch = 0; ch < NCH; ch++) begin
      if (r) begin
        m_s1[ch] = 1'b0; m_s2[ch] = 1'b0; m_out[ch] = 1'b0;
        m_rise[ch] = 1'b0; m_fall[ch] = 1'b0; m_cnt[ch] = 0;
      end else begin
        m_rise[ch] = 1'b0;
        m_fall[ch] = 1'b0;
        if (m_s2[ch] == m_out[ch]) begin
          m_cnt[ch] = 0;
        end else if (m_cnt[ch] == DCYC - 1) begin
          m_out[ch] = m_s2[ch];
          m_cnt[ch] = 0;
          m_rise[ch] = EDGE_EXP & m_s2[ch];
          m_fall[ch] = EDGE_EXP & ~m_s2[ch];
        end else begin
          m_cnt[ch] = m_cnt[ch] + 1;
        end
        m_s2[ch] = m_s1[ch];
        m_s1[ch] = in[ch];
      end
    end
  endtask

  // Driver: apply inputs, wait one edge, push the expected outputs.
  task automatic drive_cycle(input logic [NCH-1:0] in, input logic r);
    sw_in = in;
    rst   = r;
    @(posedge clk);
    model_step(in, r);
    exp_q.push_back({m_fall, m_rise, m_out});
  endtask

  task automatic test_reset();
    logic [3*NCH-1:0] e;
    for (int n = 1; n <= 3; n++) begin
      drive_cycle(2'b11, 1'b1);
      #1;
      e = exp_q.pop_front();
      n_total++;
      if ({sw_fall, sw_rise, sw_out} !== e)
        $display("FAIL reset_sb cyc=%0d got=%b exp=%b", n, {sw_fall, sw_rise, sw_out}, e);
      else n_pass++;
      n_total++;
      if ({sw_fall, sw_rise, sw_out} !== 6'b0)
        $display("FAIL reset_zero cyc=%0d got=%b exp=000000", n, {sw_fall, sw_rise, sw_out});
      else n_pass++;
    end
  endtask

  task automatic test_rise();
    logic [3*NCH-1:0] e;
    int rises = 0;
    for (int n = 1; n <= 9; n++) begin
      drive_cycle(2'b01, 1'b0);
      #1;
      e = exp_q.pop_front();
      n_total++;
      if ({sw_fall, sw_rise, sw_out} !== e)
        $display("FAIL rise_sb edge=%0d got=%b exp=%b", n, {sw_fall, sw_rise, sw_out}, e);
      else n_pass++;
      if (sw_rise[0]) rises++;
      if (n == 5) begin
        n_total++;
        if (sw_out[0] !== 1'b0) $display("FAIL rise_early edge=5 got=%b exp=0", sw_out[0]);
        else n_pass++;
      end
      if (n == 6) begin
        n_total++;
        if (sw_out[0] !== 1'b1) $display("FAIL rise_edge6 got=%b exp=1", sw_out[0]);
        else n_pass++;
        n_total++;
        if (sw_rise[0] !== EDGE_EXP) $display("FAIL rise_pulse got=%b exp=%b", sw_rise[0], EDGE_EXP);
        else n_pass++;
      end
    end
    n_total++;
    if (rises !== int'(EDGE_EXP)) $display("FAIL rise_count got=%0d exp=%0d", rises, EDGE_EXP);
    else n_pass++;
  endtask

  task automatic test_glitch();
    logic [3*NCH-1:0] e;
    logic moved = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      drive_cycle({(n <= 3), 1'b1}, 1'b0);
      #1;
      e = exp_q.pop_front();
      n_total++;
      if ({sw_fall, sw_rise, sw_out} !== e)
        $display("FAIL glitch_sb cyc=%0d got=%b exp=%b", n, {sw_fall, sw_rise, sw_out}, e);
      else n_pass++;
      if (sw_out[1] || sw_rise[1] || sw_fall[1]) moved = 1'b1;
    end
    n_total++;
    if (moved !== 1'b0) $display("FAIL glitch_ch1 got=%b exp=0", moved);
    else n_pass++;
  endtask

  task automatic test_bounce();
    logic [3*NCH-1:0] e;
    logic dropped = 1'b0;
    int falls = 0;
    for (int i = 0; i < 20; i++) begin
      drive_cycle({1'b0, ((i / 2) % 2 == 1)}, 1'b0);
      #1;
      e = exp_q.pop_front();
      n_total++;
      if ({sw_fall, sw_rise, sw_out} !== e)
        $display("FAIL bounce_sb cyc=%0d got=%b exp=%b", i, {sw_fall, sw_rise, sw_out}, e);
      else n_pass++;
      if (sw_out[0] !== 1'b1 || sw_fall[0]) dropped = 1'b1;
    end
    n_total++;
    if (dropped !== 1'b0) $display("FAIL bounce_hold got=%b exp=0", dropped);
    else n_pass++;
    for (int n = 1; n <= 9; n++) begin
      drive_cycle(2'b00, 1'b0);
      #1;
      e = exp_q.pop_front();
      n_total++;
      if ({sw_fall, sw_rise, sw_out} !== e)
        $display("FAIL settle_sb edge=%0d got=%b exp=%b", n, {sw_fall, sw_rise, sw_out}, e);
      else n_pass++;
      if (sw_fall[0]) falls++;
      if (n == 5 || n == 6) begin
        n_total++;
        if (sw_out[0] !== (n == 5))
          $display("FAIL settle_edge%0d got=%b exp=%b", n, sw_out[0], (n == 5));
        else n_pass++;
      end
    end
    n_total++;
    if (falls !== int'(EDGE_EXP)) $display("FAIL fall_count got=%0d exp=%0d", falls, EDGE_EXP);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [3*NCH-1:0] e;
    for (int n = 1; n <= 8; n++) begin
      drive_cycle(2'b11, 1'b0);
      #1;
      e = exp_q.pop_front();
      n_total++;
      if ({sw_fall, sw_rise, sw_out} !== e)
        $display("FAIL simul_sb edge=%0d got=%b exp=%b", n, {sw_fall, sw_rise, sw_out}, e);
      else n_pass++;
      if (n == 5 || n == 6) begin
        n_total++;
        if (sw_out !== ((n == 6) ? 2'b11 : 2'b00))
          $display("FAIL simul_edge%0d got=%b exp=%b", n, sw_out, (n == 6) ? 2'b11 : 2'b00);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3*NCH-1:0] e;
    // Let both channels fall back to 0 first.
    for (int n = 1; n <= 8; n++) begin
      drive_cycle(2'b00, 1'b0);
      #1;
      e = exp_q.pop_front();
      n_total++;
      if ({sw_fall, sw_rise, sw_out} !== e)
        $display("FAIL mid_pre_sb cyc=%0d got=%b exp=%b", n, {sw_fall, sw_rise, sw_out}, e);
      else n_pass++;
    end
    // Four edges of a high ch0 leave its counter at 2.
    for (int n = 1; n <= 4; n++) begin
      drive_cycle(2'b01, 1'b0);
      #1;
      e = exp_q.pop_front();
      n_total++;
      if ({sw_fall, sw_rise, sw_out} !== e)
        $display("FAIL mid_qual_sb edge=%0d got=%b exp=%b", n, {sw_fall, sw_rise, sw_out}, e);
      else n_pass++;
    end
    for (int n = 1; n <= 2; n++) begin
      drive_cycle(2'b01, 1'b1);
      #1;
      e = exp_q.pop_front();
      n_total++;
      if (sw_out !== 2'b00) $display("FAIL mid_rst_out cyc=%0d got=%b exp=00", n, sw_out);
      else n_pass++;
      n_total++;
      if ({sw_fall, sw_rise, sw_out} !== e)
        $display("FAIL mid_rst_sb cyc=%0d got=%b exp=%b", n, {sw_fall, sw_rise, sw_out}, e);
      else n_pass++;
    end
    for (int n = 1; n <= 7; n++) begin
      drive_cycle(2'b01, 1'b0);
      #1;
      e = exp_q.pop_front();
      n_total++;
      if ({sw_fall, sw_rise, sw_out} !== e)
        $display("FAIL requal_sb edge=%0d got=%b exp=%b", n, {sw_fall, sw_rise, sw_out}, e);
      else n_pass++;
      if (n == 5 || n == 6) begin
        n_total++;
        if (sw_out[0] !== (n == 6))
          $display("FAIL requal_edge%0d got=%b exp=%b", n, sw_out[0], (n == 6));
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3*NCH-1:0] e;
    logic [NCH-1:0]   v;
    int               hold;
    int               cyc = 0;
    while (cyc < 300) begin
      v    = NCH'($urandom_range(0, 3));
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++) begin
        drive_cycle(v, ($urandom_range(0, 99) == 0));
        #1;
        e = exp_q.pop_front();
        n_total++;
        if ({sw_fall, sw_rise, sw_out} !== e)
          $display("FAIL random_sb cyc=%0d got=%b exp=%b", cyc, {sw_fall, sw_rise, sw_out}, e);
        else n_pass++;
        cyc++;
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    sw_in = '0;
    m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0;
    for (int ch = 0; ch < NCH; ch++) m_cnt[ch] = 0;
    test_reset();
    test_rise();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
